// File: rtl/fifo_pkg.sv
// Shared FIFO package, used by both the read-side and write-side controllers.
// Holds the default pointer and data widths plus the binary/Gray pointer
// conversion helpers. The helpers work on 32-bit values: narrower pointers
// are zero-extended on the way in and truncated on the way out, which is
// exact for both conversions because the upper bits stay zero.
package fifo_pkg;

   localparam int POI_SIZE_DEF   = 4;   // pointer width incl. wrap bit
   localparam int DATA_WIDTH_DEF = 8;   // FIFO word width

   function automatic logic [31:0] bin2gray(input logic [31:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic logic [31:0] gray2bin(input logic [31:0] gray);
      logic [31:0] bin;
      bin[31] = gray[31];
      for (int i = 30; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter.
// Ports:
//   gray : Gray-coded input value
//   bin  : binary equivalent; each bit is the XOR of all Gray bits at or above it
module gray2bin #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         assign bin[gi] = ^gray[WIDTH-1:gi];
      end
   endgenerate

endmodule

// File: rtl/r_fifo_ctrl.sv
// Read-side controller of an asynchronous FIFO with a first-word-fall-through
// output register.
// Ports:
//   rclk, rrst     : read clock, synchronous active-high reset
//   rq2_wptr       : Gray write pointer, already synchronised into rclk
//   rdata          : memory read data for the current raddr (combinational)
//   raddr          : memory read address
//   g_rptr         : registered Gray read pointer for the write domain
//   rempty         : memory holds no words
//   ralmost_empty  : memory occupancy <= AEMPTY_THRESH
//   rlevel         : memory occupancy (the word in dout is not counted)
//   dout/dout_valid/dout_ready : output register with valid/ready handshake
module r_fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int POI_SIZE      = POI_SIZE_DEF,
   parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
   parameter int AEMPTY_THRESH = 1
) (
   input  logic                  rclk,
   input  logic                  rrst,
   input  logic [POI_SIZE-1:0]   rq2_wptr,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic [POI_SIZE-2:0]   raddr,
   output logic [POI_SIZE-1:0]   g_rptr,
   output logic                  rempty,
   output logic                  ralmost_empty,
   output logic [POI_SIZE-1:0]   rlevel,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   input  logic                  dout_ready
);

   logic [POI_SIZE-1:0]   bn_rptr_reg;
   logic [POI_SIZE-1:0]   g_rptr_reg;
   logic                  rempty_reg;
   logic                  ralmost_empty_reg;
   logic [POI_SIZE-1:0]   rlevel_reg;
   logic [DATA_WIDTH-1:0] dout_reg;
   logic                  dout_valid_reg;

   logic                  fetch;
   logic [POI_SIZE-1:0]   rptr_next;
   logic [POI_SIZE-1:0]   g_rptr_next;
   logic [POI_SIZE-1:0]   wptr_bin;
   logic [POI_SIZE-1:0]   level_next;

   gray2bin #(
      .WIDTH (POI_SIZE)
   ) u_wptr_g2b (
      .gray (rq2_wptr),
      .bin  (wptr_bin)
   );

   // Pull a word from memory whenever one exists and the output register is
   // free or being emptied this cycle; this gives 1 word/cycle streaming.
   assign fetch       = !rempty_reg && (!dout_valid_reg || dout_ready);
   assign rptr_next   = bn_rptr_reg + POI_SIZE'(fetch);
   assign g_rptr_next = POI_SIZE'(bin2gray(32'(rptr_next)));
   // Occupancy is computed from the post-fetch pointer so that the flags
   // and level registered this cycle already account for the word taken.
   assign level_next  = wptr_bin - rptr_next;

   always_ff @(posedge rclk) begin
      if (rrst) begin
         bn_rptr_reg       <= '0;
         g_rptr_reg        <= '0;
         rempty_reg        <= 1'b1;
         ralmost_empty_reg <= 1'b1;
         rlevel_reg        <= '0;
         dout_reg          <= '0;
         dout_valid_reg    <= 1'b0;
      end else begin
         bn_rptr_reg       <= rptr_next;
         g_rptr_reg        <= g_rptr_next;
         rempty_reg        <= (g_rptr_next == rq2_wptr);
         rlevel_reg        <= level_next;
         ralmost_empty_reg <= (level_next <= POI_SIZE'(AEMPTY_THRESH));
         if (fetch) begin
            dout_reg       <= rdata;
            dout_valid_reg <= 1'b1;
         end else if (dout_valid_reg && dout_ready) begin
            dout_valid_reg <= 1'b0;
         end
      end
   end

   assign raddr         = bn_rptr_reg[POI_SIZE-2:0];
   assign g_rptr        = g_rptr_reg;
   assign rempty        = rempty_reg;
   assign ralmost_empty = ralmost_empty_reg;
   assign rlevel        = rlevel_reg;
   assign dout          = dout_reg;
   assign dout_valid    = dout_valid_reg;

endmodule

// File: tb/tb_r_fifo_ctrl.sv
module tb_r_fifo_ctrl;

   logic       rclk = 1'b0;
   logic       rrst;
   logic [3:0] rq2_wptr;
   logic [7:0] rdata;
   logic [2:0] raddr;
   logic [3:0] g_rptr;
   logic       rempty;
   logic       ralmost_empty;
   logic [3:0] rlevel;
   logic [7:0] dout;
   logic       dout_valid;
   logic       dout_ready;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [8];
   logic [3:0] wbin;
   logic [7:0] sb_q [$];

   logic [3:0] g_prev    = 4'b0000;
   logic       rrst_prev = 1'b1;

   always #5 rclk = ~rclk;

   assign rdata = mem[raddr];

   r_fifo_ctrl #(
      .POI_SIZE      (4),
      .DATA_WIDTH    (8),
      .AEMPTY_THRESH (1)
   ) dut (
      .rclk          (rclk),
      .rrst          (rrst),
      .rq2_wptr      (rq2_wptr),
      .rdata         (rdata),
      .raddr         (raddr),
      .g_rptr        (g_rptr),
      .rempty        (rempty),
      .ralmost_empty (ralmost_empty),
      .rlevel        (rlevel),
      .dout          (dout),
      .dout_valid    (dout_valid),
      .dout_ready    (dout_ready)
   );

   // Scoreboard consumer and Gray single-step monitor, sampled mid-cycle.
   always @(negedge rclk) begin
      if (!rrst && dout_valid && dout_ready) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_extra: dout=%h consumed but no word expected", dout);
         end else begin
            logic [7:0] exp_d;
            exp_d = sb_q.pop_front();
            if (dout !== exp_d) begin
               errors++;
               $display("FAIL sb_data: dout=%h expected %h", dout, exp_d);
            end else begin
               $display("consume dout=%h", dout);
            end
         end
      end
      if (!rrst_prev) begin
         checks++;
         if ($countones(g_rptr ^ g_prev) > 1) begin
            errors++;
            $display("FAIL gray_step: g_rptr %b -> %b", g_prev, g_rptr);
         end
      end
      g_prev    = g_rptr;
      rrst_prev = rrst;
   end

   task automatic tick();
      @(posedge rclk);
      #1;
   endtask

   task automatic publish();
      rq2_wptr = wbin ^ (wbin >> 1);
   endtask

   task automatic write_word(input logic [7:0] d);
      mem[wbin[2:0]] = d;
      sb_q.push_back(d);
      wbin = wbin + 4'd1;
      publish();
   endtask

   task automatic write_words(input int n);
      for (int i = 0; i < n; i++) begin
         mem[wbin[2:0]] = 8'($urandom_range(255));
         sb_q.push_back(mem[wbin[2:0]]);
         wbin = wbin + 4'd1;
      end
      publish();
   endtask

   task automatic do_reset();
      rrst       = 1'b1;
      dout_ready = 1'b0;
      wbin       = 4'd0;
      publish();
      sb_q.delete();
      tick();
      tick();
      rrst = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      dout_ready = 1'b1;
      n = 0;
      while (!(rempty && !dout_valid && sb_q.size() == 0) && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 40) begin
         errors++;
         $display("FAIL %s_drain: timeout, rempty=%b dout_valid=%b pending=%0d",
                  name, rempty, dout_valid, sb_q.size());
      end
      dout_ready = 1'b0;
   endtask

   task automatic test_reset();
      rrst       = 1'b1;
      dout_ready = 1'b0;
      for (int i = 0; i < 8; i++) mem[i] = 8'h00;
      mem[0] = 8'h11;
      mem[1] = 8'h22;
      sb_q.delete();
      sb_q.push_back(8'h11);
      sb_q.push_back(8'h22);
      wbin     = 4'd2;
      rq2_wptr = 4'b0011;
      tick();
      tick();
      checks++;
      if (rempty !== 1'b1 || dout_valid !== 1'b0 || g_rptr !== 4'b0000 ||
          rlevel !== 4'd0 || ralmost_empty !== 1'b1 || dout !== 8'h00) begin
         errors++;
         $display("FAIL reset_state: rempty=%b dv=%b g=%b lvl=%0d ae=%b dout=%h required 1 0 0000 0 1 00",
                  rempty, dout_valid, g_rptr, rlevel, ralmost_empty, dout);
      end
      rrst = 1'b0;
      tick();
      checks++;
      if (rempty !== 1'b0 || rlevel !== 4'd2) begin
         errors++;
         $display("FAIL reset_release: rempty=%b rlevel=%0d required 0 2", rempty, rlevel);
      end
      $display("reset: rempty=%b rlevel=%0d", rempty, rlevel);
      drain("reset");
   endtask

   task automatic test_single();
      do_reset();
      write_word(8'hA5);
      tick();
      checks++;
      if (rempty !== 1'b0 || dout_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_lat1: rempty=%b dv=%b required 0 0", rempty, dout_valid);
      end
      tick();
      checks++;
      if (dout_valid !== 1'b1 || dout !== 8'hA5 || rempty !== 1'b1 || g_rptr !== 4'b0001 ||
          rlevel !== 4'd0) begin
         errors++;
         $display("FAIL single_lat2: dv=%b dout=%h rempty=%b g=%b lvl=%0d required 1 a5 1 0001 0",
                  dout_valid, dout, rempty, g_rptr, rlevel);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (dout_valid !== 1'b1 || dout !== 8'hA5 || raddr !== 3'd1) begin
            errors++;
            $display("FAIL single_hold: dv=%b dout=%h raddr=%0d required 1 a5 1",
                     dout_valid, dout, raddr);
         end
      end
      $display("single: dout=%h held", dout);
      drain("single");
   endtask

   task automatic test_idle_empty();
      logic [3:0] g0;
      logic [2:0] a0;
      g0 = g_rptr;
      a0 = raddr;
      dout_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (g_rptr !== g0 || raddr !== a0 || dout_valid !== 1'b0 || rempty !== 1'b1) begin
            errors++;
            $display("FAIL idle_empty: g=%b raddr=%0d dv=%b rempty=%b required %b %0d 0 1",
                     g_rptr, raddr, dout_valid, rempty, g0, a0);
         end
      end
      dout_ready = 1'b0;
      $display("idle_empty: g_rptr=%b stable", g_rptr);
   endtask

   task automatic test_stream();
      int n;
      int run;
      do_reset();
      dout_ready = 1'b1;
      write_words(8);
      checks++;
      if (rq2_wptr !== 4'b1100) begin
         errors++;
         $display("FAIL stream_wptr: rq2_wptr=%b required 1100", rq2_wptr);
      end
      n = 0;
      while (!dout_valid && n < 5) begin
         tick();
         n++;
      end
      run = 0;
      while (dout_valid && run < 12) begin
         tick();
         run++;
      end
      checks++;
      if (run !== 8) begin
         errors++;
         $display("FAIL stream_run: valid run=%0d required 8", run);
      end
      checks++;
      if (g_rptr !== 4'b1100 || rempty !== 1'b1) begin
         errors++;
         $display("FAIL stream_end: g=%b rempty=%b required 1100 1", g_rptr, rempty);
      end
      $display("stream: run=%0d g_rptr=%b", run, g_rptr);
      dout_ready = 1'b0;
   endtask

   task automatic test_wrap();
      write_words(7);
      drain("wrap_pre");
      checks++;
      if (g_rptr !== 4'b1000) begin
         errors++;
         $display("FAIL wrap_pre: g_rptr=%b required 1000", g_rptr);
      end
      write_word(8'h5C);
      tick();
      tick();
      checks++;
      if (dout_valid !== 1'b1 || dout !== 8'h5C || g_rptr !== 4'b0000 || rempty !== 1'b1) begin
         errors++;
         $display("FAIL wrap_post: dv=%b dout=%h g=%b rempty=%b required 1 5c 0000 1",
                  dout_valid, dout, g_rptr, rempty);
      end
      $display("wrap: g_rptr=%b dout=%h", g_rptr, dout);
      drain("wrap");
   endtask

   task automatic test_backpressure();
      logic       rdy_seq [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [3:0] lvl_seq [7] = '{4'd3, 4'd2, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0};
      do_reset();
      write_words(3);
      for (int i = 0; i < 7; i++) begin
         dout_ready = rdy_seq[i];
         tick();
         checks++;
         if (rlevel !== lvl_seq[i] || ralmost_empty !== (lvl_seq[i] <= 4'd1)) begin
            errors++;
            $display("FAIL bp_level[%0d]: rlevel=%0d ae=%b required %0d %b",
                     i, rlevel, ralmost_empty, lvl_seq[i], (lvl_seq[i] <= 4'd1));
         end
      end
      checks++;
      if (sb_q.size() != 0 || dout_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_done: pending=%0d dv=%b required 0 0", sb_q.size(), dout_valid);
      end
      $display("backpressure: rlevel=%0d pending=%0d", rlevel, sb_q.size());
      dout_ready = 1'b0;
   endtask

   task automatic test_mid_reset();
      do_reset();
      write_words(5);
      tick();
      tick();
      checks++;
      if (dout_valid !== 1'b1 || rlevel !== 4'd4) begin
         errors++;
         $display("FAIL midrst_pre: dv=%b rlevel=%0d required 1 4", dout_valid, rlevel);
      end
      rrst       = 1'b1;
      dout_ready = 1'b1;
      tick();
      checks++;
      if (rempty !== 1'b1 || dout_valid !== 1'b0 || g_rptr !== 4'b0000 || rlevel !== 4'd0 ||
          ralmost_empty !== 1'b1 || dout !== 8'h00 || raddr !== 3'd0) begin
         errors++;
         $display("FAIL midrst_post: rempty=%b dv=%b g=%b lvl=%0d ae=%b dout=%h raddr=%0d required 1 0 0000 0 1 00 0",
                  rempty, dout_valid, g_rptr, rlevel, ralmost_empty, dout, raddr);
      end
      $display("mid_reset: dv=%b rlevel=%0d", dout_valid, rlevel);
      do_reset();
      write_word(8'h3E);
      drain("midrst");
   endtask

   initial begin
      rrst       = 1'b1;
      dout_ready = 1'b0;
      rq2_wptr   = 4'b0000;
      wbin       = 4'd0;
      test_reset();
      test_single();
      test_idle_empty();
      test_stream();
      test_wrap();
      test_backpressure();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d required completion", errors);
      $fatal(1, "watchdog timeout");
   end

endmodule

// File: doc/r_fifo_ctrl.md
R_FIFO_CTRL -- requirements
Module: r_fifo_ctrl

Interface
REQ-001 SHALL have parameter POI_SIZE, default 4, meaning pointer width including wrap bit (FIFO depth = 2^(POI_SIZE-1)).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning FIFO word width.
REQ-003 SHALL have parameter AEMPTY_THRESH, default 1, meaning the memory occupancy at or below which ralmost_empty asserts.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 rclk  input  1  read-domain clock; all state updates on the rising edge.
REQ-006 rrst  input  1  synchronous active-high reset.
REQ-007 rq2_wptr  input  POI_SIZE  Gray write pointer, already double-synchronised into rclk.
REQ-008 rdata  input  DATA_WIDTH  memory read data, combinationally valid for the current raddr.
REQ-009 raddr  output  POI_SIZE-1  memory read address.
REQ-010 g_rptr  output  POI_SIZE  registered Gray read pointer, sent to the write domain.
REQ-011 rempty  output  1  registered memory-empty flag.
REQ-012 ralmost_empty  output  1  registered flag; high when rlevel <= AEMPTY_THRESH.
REQ-013 rlevel  output  POI_SIZE  registered count of words held in memory, excluding dout.
REQ-014 dout  output  DATA_WIDTH  first-word-fall-through output register.
REQ-015 dout_valid  output  1  dout holds an unconsumed word.
REQ-016 dout_ready  input  1  consumer accepts dout when dout_valid is high.

Function
REQ-017 SHALL keep a binary read pointer bn_rptr; raddr SHALL equal bn_rptr[POI_SIZE-2:0].
REQ-018 SHALL define fetch = !rempty && (!dout_valid || dout_ready).
REQ-019 On fetch: dout <= rdata, dout_valid <= 1, bn_rptr <= bn_rptr+1 (modulo 2^POI_SIZE).
REQ-020 On dout_valid && dout_ready && !fetch: dout_valid <= 0 and dout holds its value.
REQ-021 When dout_valid is high and dout_ready is low, dout and dout_valid SHALL hold.
REQ-022 Define rptr_next = bn_rptr+fetch. g_rptr SHALL register bin2gray(rptr_next), so it changes in the same cycle as bn_rptr.
REQ-023 rempty SHALL register (bin2gray(rptr_next) == rq2_wptr).
REQ-024 rlevel SHALL register (gray2bin(rq2_wptr) - rptr_next), modulo 2^POI_SIZE.
REQ-025 ralmost_empty SHALL register (gray2bin(rq2_wptr) - rptr_next) <= AEMPTY_THRESH.
REQ-026 g_rptr SHALL change by exactly one bit per cycle, including on the wrap from 2^POI_SIZE-1 to 0.
REQ-027 Latency: a word becoming visible on rq2_wptr SHALL deassert rempty 1 cycle later, and SHALL appear on dout with dout_valid high 2 cycles after it becomes visible, provided dout is empty or being consumed.
REQ-028 Simultaneous consume and fetch SHALL give back-to-back throughput of 1 word/cycle with no bubble.
REQ-029 When rempty is high, no pointer or memory-read activity SHALL occur regardless of dout_ready.
REQ-030 A word transferred to dout SHALL never be lost or duplicated.

Reset
REQ-031 rrst high at a clock edge SHALL set bn_rptr=0, g_rptr=0, rempty=1, ralmost_empty=1, rlevel=0, dout=0 and dout_valid=0.
REQ-032 Reset SHALL take priority over fetch and consume, including in the middle of a transfer; any word held in dout is discarded.

Structure
REQ-033 Shared package fifo_pkg SHALL hold the bin2gray and gray2bin functions and the POI_SIZE and DATA_WIDTH defaults; the write side uses the same package.
REQ-034 Gray-to-binary conversion of rq2_wptr SHALL be a sub-module gray2bin (parameter WIDTH); the rest is flat in r_fifo_ctrl.

Verification
REQ-035 Reset: rrst=1 for 2 cycles with rq2_wptr=4'b0011 -> rempty=1, dout_valid=0, g_rptr=0; after release, rempty=0 and rlevel=2 one cycle later.
REQ-036 Single word: rq2_wptr 0000->0001, rdata=8'hA5, dout_ready=0 -> dout=8'hA5 and dout_valid=1 two cycles later; rempty=1, g_rptr=0001; dout holds while dout_ready=0.
REQ-037 Streaming: rq2_wptr=4'b1100 (8 words), dout_ready=1 -> 8 consecutive valid cycles with no bubble; final g_rptr=1100 and rempty=1.
REQ-038 Wrap: start with bn_rptr=15, one word available -> bn_rptr wraps to 0, g_rptr goes 1000->0000 (one bit changes), and the word is delivered correctly.
REQ-039 Backpressure: 3 words available, dout_ready toggles 1,0,0,1,1 -> words are delivered in order with none dropped or duplicated; rlevel goes 3->2->1->1->1->0 and ralmost_empty asserts when rlevel<=1.
REQ-040 Mid-operation reset: rrst pulsed while dout_valid=1 and rlevel=4 -> all outputs take their REQ-031 values in the next cycle.
